// File: rtl/rt_mem_dump_reader.sv
// rt_mem_dump_reader
// Read-back engine for the racetrack LiM data memory. On start_i it walks a
// word-aligned byte-address range on memory port B, issuing one read per word
// (a one-cycle en_b_o pulse with we_b_o low) and waiting for rvalid_b_i. Each
// captured word is presented on a valid/ready stream together with the byte
// address it came from.
//
// Optional feature macro: RT_DUMP_CHECKSUM_EN
//   defined   : checksum_o is the modulo-2^32 sum of every word accepted on the
//               stream (cleared on an accepted start, holds after done_o).
//   undefined : checksum_o is tied to 0 and no adder is built.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   start_i               launch a dump (sampled only in IDLE)
//   base_addr_i           first byte address, bits [1:0] ignored
//   num_words_i           number of 32-bit words to read
//   busy_o, done_o        status: busy from cycle after start until DONE left,
//                         one-cycle done pulse at end of dump
//   error_o               sticky read timeout flag
//   en_b_o, we_b_o, be_b_o, addr_b_o, rdata_b_i, rvalid_b_i   memory port B
//   data_o, data_addr_o, data_valid_o, data_ready_i           output stream
//   checksum_o            running checksum of streamed words
//   state_o               current FSM state, for debug/checkers
//
// Stream handshake: data_valid_o rises with data_o/data_addr_o already valid
// and all three stay stable until a cycle where data_valid_o & data_ready_i
// are both high; that cycle transfers the word. data_valid_o never drops
// without a transfer, and data_ready_i may be driven independently of valid.

module rt_mem_dump_reader #(
  parameter int ADDR_WIDTH     = 22,
  parameter int CNT_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  en_b_o,
  output logic                  we_b_o,
  output logic [3:0]            be_b_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  input  logic [31:0]           rdata_b_i,
  input  logic                  rvalid_b_i,
  output logic [31:0]           data_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [31:0]           checksum_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [TW-1:0]          tcnt;
  logic [TW-1:0]          tcnt_inc;
  logic                   start_accept;
  logic                   handshake;
  logic                   unused_base_lsbs;

  // Byte offset within the word is discarded; reads are always word aligned.
  assign unused_base_lsbs = ^base_addr_i[1:0];

  assign tcnt_inc     = tcnt + TW'(1);
  assign start_accept = (state == S_IDLE) && start_i;
  assign handshake    = (state == S_OUT) && data_ready_i;

  // Port B is read-only from this engine.
  assign we_b_o  = 1'b0;
  assign be_b_o  = 4'hF;
  assign state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      en_b_o       <= 1'b0;
      addr_b_o     <= '0;
      data_o       <= '0;
      data_addr_o  <= '0;
      data_valid_o <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      en_b_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            addr_b_o <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
            cnt      <= num_words_i;
            error_o  <= 1'b0;
            busy_o   <= 1'b1;
            if (num_words_i == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= S_REQ;
              en_b_o <= 1'b1;
            end
          end
        end
        S_REQ: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Capture has priority over a timeout landing in the same cycle.
          if (rvalid_b_i) begin
            data_o       <= rdata_b_i;
            data_addr_o  <= addr_b_o;
            data_valid_o <= 1'b1;
            state        <= S_OUT;
          end else if (tcnt_inc == TO_LAST) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            state   <= S_DONE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_OUT: begin
          if (data_ready_i) begin
            data_valid_o <= 1'b0;
            addr_b_o     <= addr_b_o + ADDR_WIDTH'(4);
            cnt          <= cnt - CNT_WIDTH'(1);
            if (cnt == CNT_WIDTH'(1)) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= S_REQ;
              en_b_o <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RT_DUMP_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (start_accept) begin
      sum_q <= '0;
    end else if (handshake) begin
      sum_q <= sum_q + data_o;
    end
  end

  assign checksum_o = sum_q;
`else
  logic unused_sum_ctl;

  assign unused_sum_ctl = start_accept ^ handshake;
  assign checksum_o     = 32'h0;
`endif

endmodule
